// File: rtl/vec_mul_pkg.sv
// Shared state encoding and default sizing for the vector-multiply sequencer.
package vec_mul_pkg;

  localparam int DEF_ADDRESSSIZE  = 10;
  localparam int DEF_MATRIX_SIZE  = 32;
  localparam int DEF_WLOAD_CYCLES = DEF_MATRIX_SIZE;
  localparam int DEF_PIPE_LATENCY = DEF_MATRIX_SIZE + 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WLOAD  = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    FINISH = 3'd4
  } state_t;

endpackage

// File: rtl/vec_mul_sequencer_if.sv
// Command, weight-FIFO, unified-buffer and result-SRAM signals of the sequencer.
interface vec_mul_sequencer_if
  import vec_mul_pkg::*;
#(
  parameter int ADDRESSSIZE = DEF_ADDRESSSIZE
) ();

  logic                   start;
  logic                   abort;
  logic                   reload_req;
  logic [ADDRESSSIZE-1:0] num_vecs;
  logic [ADDRESSSIZE-1:0] src_base;
  logic [ADDRESSSIZE-1:0] dst_base;
  logic                   fifo_empty;
  logic                   fifo_read_enable;
  logic                   weight_reload;
  logic [ADDRESSSIZE-1:0] ub_address;
  logic                   ub_valid;
  logic                   res_write_enable;
  logic [ADDRESSSIZE-1:0] res_address;
  logic                   busy;
  logic                   done;
  logic                   err;

  // master: the sequencer itself
  modport master (
    input  start, abort, reload_req, num_vecs, src_base, dst_base, fifo_empty,
    output fifo_read_enable, weight_reload, ub_address, ub_valid,
           res_write_enable, res_address, busy, done, err
  );

  // slave: host and datapath around the sequencer
  modport slave (
    output start, abort, reload_req, num_vecs, src_base, dst_base, fifo_empty,
    input  fifo_read_enable, weight_reload, ub_address, ub_valid,
           res_write_enable, res_address, busy, done, err
  );

endinterface

// File: rtl/valid_delay_line.sv
// Fixed-depth shift register that delays the issue strobe to the array output.
module valid_delay_line #(
  parameter int DEPTH = 34
) (
  input  logic clk,
  input  logic rstn,
  input  logic flush,
  input  logic valid,
  output logic delayed
);

  logic [DEPTH:0] chain;

  assign chain[0] = valid;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic stage_reg;

      always_ff @(posedge clk) begin
        if (!rstn || flush) begin
          stage_reg <= 1'b0;
        end else begin
          stage_reg <= chain[gi];
        end
      end

      assign chain[gi+1] = stage_reg;
    end
  endgenerate

  assign delayed = chain[DEPTH];

endmodule

// File: rtl/vec_mul_sequencer.sv
// Sequences one job: optional weight-tile load, vector streaming, result drain.
module vec_mul_sequencer
  import vec_mul_pkg::*;
#(
  parameter int ADDRESSSIZE  = DEF_ADDRESSSIZE,
  parameter int MATRIX_SIZE  = DEF_MATRIX_SIZE,
  parameter int WLOAD_CYCLES = MATRIX_SIZE,
  parameter int PIPE_LATENCY = MATRIX_SIZE + 2
) (
  input logic                 clk,
  input logic                 rstn,
  vec_mul_sequencer_if.master bus
);

  localparam int WLW = $clog2(WLOAD_CYCLES + 1);

  state_t                 state_reg;
  state_t                 state_next;
  logic [ADDRESSSIZE-1:0] num_reg;
  logic [ADDRESSSIZE-1:0] src_ptr_reg;
  logic [ADDRESSSIZE-1:0] res_ptr_reg;
  logic [ADDRESSSIZE-1:0] ub_last_reg;
  logic [ADDRESSSIZE-1:0] res_last_reg;
  logic [ADDRESSSIZE-1:0] issue_cnt_reg;
  logic [ADDRESSSIZE-1:0] write_cnt_reg;
  logic [WLW-1:0]         wl_cnt_reg;

  logic accept;
  logic issue;
  logic write_en;
  logic flush;

  assign accept = (state_reg == IDLE) && bus.start && !bus.abort;
  assign issue  = (state_reg == STREAM);
  assign flush  = (state_reg != IDLE) && bus.abort;

  valid_delay_line #(
    .DEPTH (PIPE_LATENCY)
  ) u_delay (
    .clk     (clk),
    .rstn    (rstn),
    .flush   (flush),
    .valid   (issue),
    .delayed (write_en)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            if (bus.num_vecs == '0)    state_next = FINISH;
            else if (bus.reload_req)  state_next = WLOAD;
            else                      state_next = STREAM;
          end
        end
        WLOAD: begin
          // first WLOAD cycle decides between popping a tile and erroring out
          if (wl_cnt_reg == '0) begin
            if (bus.fifo_empty) state_next = IDLE;
          end else if (wl_cnt_reg == WLW'(WLOAD_CYCLES)) begin
            state_next = STREAM;
          end
        end
        STREAM: begin
          if (issue_cnt_reg == num_reg - ADDRESSSIZE'(1)) state_next = DRAIN;
        end
        DRAIN: begin
          if (write_cnt_reg == num_reg) state_next = FINISH;
        end
        FINISH:  state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.busy             = (state_reg != IDLE);
    bus.done             = (state_reg == FINISH) && !bus.abort;
    bus.err              = 1'b0;
    bus.fifo_read_enable = 1'b0;
    bus.weight_reload    = 1'b0;
    bus.ub_valid         = issue;
    bus.ub_address       = issue ? src_ptr_reg : ub_last_reg;
    bus.res_write_enable = write_en;
    bus.res_address      = write_en ? res_ptr_reg : res_last_reg;
    if (state_reg == WLOAD) begin
      if (wl_cnt_reg == '0) begin
        bus.fifo_read_enable = !bus.fifo_empty && !bus.abort;
        bus.err              = bus.fifo_empty && !bus.abort;
      end else begin
        bus.weight_reload = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      num_reg       <= '0;
      src_ptr_reg   <= '0;
      res_ptr_reg   <= '0;
      ub_last_reg   <= '0;
      res_last_reg  <= '0;
      issue_cnt_reg <= '0;
      write_cnt_reg <= '0;
      wl_cnt_reg    <= '0;
    end else begin
      if (state_reg == WLOAD) begin
        wl_cnt_reg <= wl_cnt_reg + WLW'(1);
      end
      if (issue) begin
        ub_last_reg   <= src_ptr_reg;
        src_ptr_reg   <= src_ptr_reg + ADDRESSSIZE'(1);
        issue_cnt_reg <= issue_cnt_reg + ADDRESSSIZE'(1);
      end
      if (write_en) begin
        res_last_reg  <= res_ptr_reg;
        res_ptr_reg   <= res_ptr_reg + ADDRESSSIZE'(1);
        write_cnt_reg <= write_cnt_reg + ADDRESSSIZE'(1);
      end
      // job parameters are captured last so a new job always starts clean
      if (accept) begin
        num_reg       <= bus.num_vecs;
        src_ptr_reg   <= bus.src_base;
        res_ptr_reg   <= bus.dst_base;
        issue_cnt_reg <= '0;
        write_cnt_reg <= '0;
        wl_cnt_reg    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_vec_mul_sequencer.sv
// Directed bench for vec_mul_sequencer with default sizing (10-bit addresses, 32x32 array).
module tb_vec_mul_sequencer;

  logic clk;
  logic rstn;

  int checks = 0;
  int errors = 0;

  int ub_a[$];
  int ub_c[$];
  int res_a[$];
  int res_c[$];
  int n_pop, pop_c, n_wr, wr_first, wr_last, n_done, done_c, n_err, err_c, last_busy;

  vec_mul_sequencer_if #(.ADDRESSSIZE(10)) bus ();

  vec_mul_sequencer #(
    .ADDRESSSIZE  (10),
    .MATRIX_SIZE  (32),
    .WLOAD_CYCLES (32),
    .PIPE_LATENCY (34)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  function automatic logic [31:0] flags();
    return {25'd0, bus.busy, bus.done, bus.err, bus.fifo_read_enable,
            bus.weight_reload, bus.ub_valid, bus.res_write_enable};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic reload, input int num, input int src, input int dst);
    bus.reload_req = reload;
    bus.num_vecs   = 10'(num);
    bus.src_base   = 10'(src);
    bus.dst_base   = 10'(dst);
    bus.start      = 1'b1;
    tick();
    bus.start      = 1'b0;
  endtask

  // Cycle c counts edges after the edge that accepted start.
  task automatic observe(input int n, input int abort_cyc, input int restart_cyc);
    ub_a.delete(); ub_c.delete(); res_a.delete(); res_c.delete();
    n_pop = 0; pop_c = -1; n_wr = 0; wr_first = -1; wr_last = -1;
    n_done = 0; done_c = -1; n_err = 0; err_c = -1; last_busy = 0;
    for (int c = 1; c <= n; c++) begin
      if (bus.ub_valid)         begin ub_a.push_back(int'(bus.ub_address)); ub_c.push_back(c); end
      if (bus.res_write_enable) begin res_a.push_back(int'(bus.res_address)); res_c.push_back(c); end
      if (bus.fifo_read_enable) begin n_pop++; pop_c = c; end
      if (bus.weight_reload)    begin n_wr++; if (wr_first < 0) wr_first = c; wr_last = c; end
      if (bus.done)             begin n_done++; done_c = c; end
      if (bus.err)              begin n_err++; err_c = c; end
      if (bus.busy)             last_busy = c;
      bus.abort = (c == abort_cyc);
      if (c == restart_cyc) begin
        bus.start    = 1'b1;
        bus.num_vecs = 10'd9;
        bus.src_base = 10'd500;
      end else begin
        bus.start = 1'b0;
      end
      tick();
    end
    bus.abort = 1'b0;
    bus.start = 1'b0;
  endtask

  initial begin
    rstn = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.reload_req = 1'b0; bus.fifo_empty = 1'b0;
    bus.num_vecs = '0; bus.src_base = '0; bus.dst_base = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_flags", flags(), 32'd0);
    chk("reset_ub_address", 32'(bus.ub_address), 32'd0);
    chk("reset_res_address", 32'(bus.res_address), 32'd0);
    rstn = 1'b1;
    tick();

    // Job A: plain stream, a second start during the job must be ignored
    start_job(1'b0, 4, 10, 0);
    observe(45, 0, 5);
    $display("job A: issues=%0d writes=%0d done_cycle=%0d", ub_a.size(), res_a.size(), done_c);
    chk("A_issue_count", ub_a.size(), 4);
    chk("A_ub_addr0", qget(ub_a, 0), 10);
    chk("A_ub_addr3", qget(ub_a, 3), 13);
    chk("A_ub_cyc0", qget(ub_c, 0), 1);
    chk("A_ub_cyc3", qget(ub_c, 3), 4);
    chk("A_write_count", res_a.size(), 4);
    chk("A_res_addr0", qget(res_a, 0), 0);
    chk("A_res_addr3", qget(res_a, 3), 3);
    chk("A_res_cyc0", qget(res_c, 0), 35);
    chk("A_res_cyc3", qget(res_c, 3), 38);
    chk("A_done_count", n_done, 1);
    chk("A_done_cycle", done_c, 40);
    chk("A_last_busy", last_busy, 40);
    chk("A_no_pop", n_pop, 0);
    chk("A_ub_hold", 32'(bus.ub_address), 32'd13);
    chk("A_res_hold", 32'(bus.res_address), 32'd3);

    // Job B: weight reload then a single vector
    start_job(1'b1, 1, 100, 200);
    observe(80, 0, 0);
    $display("job B: pops=%0d reload_cycles=%0d issues=%0d writes=%0d done_cycle=%0d",
             n_pop, n_wr, ub_a.size(), res_a.size(), done_c);
    chk("B_pop_count", n_pop, 1);
    chk("B_pop_cycle", pop_c, 1);
    chk("B_reload_count", n_wr, 32);
    chk("B_reload_first", wr_first, 2);
    chk("B_reload_last", wr_last, 33);
    chk("B_issue_count", ub_a.size(), 1);
    chk("B_ub_addr", qget(ub_a, 0), 100);
    chk("B_ub_cyc", qget(ub_c, 0), 34);
    chk("B_write_count", res_a.size(), 1);
    chk("B_res_addr", qget(res_a, 0), 200);
    chk("B_res_cyc", qget(res_c, 0), 68);
    chk("B_done_cycle", done_c, 70);

    // Job C: reload requested with an empty FIFO
    bus.fifo_empty = 1'b1;
    start_job(1'b1, 5, 0, 0);
    observe(10, 0, 0);
    bus.fifo_empty = 1'b0;
    $display("job C: err_cycle=%0d pops=%0d dones=%0d", err_c, n_pop, n_done);
    chk("C_err_count", n_err, 1);
    chk("C_err_cycle", err_c, 1);
    chk("C_last_busy", last_busy, 1);
    chk("C_no_pop", n_pop, 0);
    chk("C_no_done", n_done, 0);
    chk("C_no_issue", ub_a.size(), 0);

    // Job D: both address pointers wrap
    start_job(1'b0, 3, 1022, 1023);
    observe(45, 0, 0);
    $display("job D: ub=%0d,%0d,%0d res=%0d,%0d,%0d done_cycle=%0d",
             qget(ub_a, 0), qget(ub_a, 1), qget(ub_a, 2),
             qget(res_a, 0), qget(res_a, 1), qget(res_a, 2), done_c);
    chk("D_ub_addr0", qget(ub_a, 0), 1022);
    chk("D_ub_addr1", qget(ub_a, 1), 1023);
    chk("D_ub_addr2", qget(ub_a, 2), 0);
    chk("D_res_addr0", qget(res_a, 0), 1023);
    chk("D_res_addr1", qget(res_a, 1), 0);
    chk("D_res_addr2", qget(res_a, 2), 1);
    chk("D_done_cycle", done_c, 39);

    // Job E: abort in DRAIN with both writes still in flight
    start_job(1'b0, 2, 5, 7);
    observe(50, 10, 0);
    $display("job E: issues=%0d writes=%0d dones=%0d last_busy=%0d",
             ub_a.size(), res_a.size(), n_done, last_busy);
    chk("E_issue_count", ub_a.size(), 2);
    chk("E_no_write", res_a.size(), 0);
    chk("E_no_done", n_done, 0);
    chk("E_last_busy", last_busy, 10);

    // Job F: zero-length job goes straight to FINISH
    start_job(1'b0, 0, 0, 0);
    observe(5, 0, 0);
    $display("job F: issues=%0d done_cycle=%0d", ub_a.size(), done_c);
    chk("F_done_cycle", done_c, 1);
    chk("F_no_issue", ub_a.size(), 0);

    // Job G: start and abort together in IDLE
    bus.abort = 1'b1;
    start_job(1'b0, 2, 0, 0);
    bus.abort = 1'b0;
    chk("G_busy", 32'(bus.busy), 32'd0);
    observe(10, 0, 0);
    $display("job G: issues=%0d dones=%0d", ub_a.size(), n_done);
    chk("G_no_issue", ub_a.size(), 0);

    // Job H: reset in the middle of STREAM
    start_job(1'b0, 20, 0, 0);
    repeat (4) tick();
    chk("H_streaming", 32'(bus.ub_valid), 32'd1);
    rstn = 1'b0;
    tick();
    chk("H_reset_flags", flags(), 32'd0);
    chk("H_reset_ub_address", 32'(bus.ub_address), 32'd0);
    chk("H_reset_res_address", 32'(bus.res_address), 32'd0);
    rstn = 1'b1;
    observe(45, 0, 0);
    $display("job H: writes_after_reset=%0d dones=%0d", res_a.size(), n_done);
    chk("H_no_write", res_a.size(), 0);
    chk("H_no_done", n_done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
